// File: rtl/loader_pkg.sv
// Shared encodings for the program loader: FSM states, UART command bytes, halt word.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_IDLE      = 3'd1,
    ST_LOAD      = 3'd2,
    ST_RUN       = 3'd3,
    ST_STEP      = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  localparam logic [7:0]  CMD_LOAD  = 8'h01;
  localparam logic [7:0]  CMD_RUN   = 8'h02;
  localparam logic [7:0]  CMD_STEP  = 8'h03;
  localparam logic [7:0]  CMD_ABORT = 8'h04;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  // The CPU only leaves reset while it is running, stepping or parked after halt.
  function automatic logic cpu_in_reset(input state_e s);
    return !(s == ST_RUN || s == ST_STEP || s == ST_DONE);
  endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Packs UART bytes MSB-first into instruction words and pulses when a word is complete.
module word_assembler #(
  parameter int NBITS = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             byte_vld_i,
  input  logic [7:0]       byte_i,
  output logic             done_o,      // last byte of a word accepted this cycle
  output logic [NBITS-1:0] word_nxt_o,  // word as it will look including byte_i
  output logic [NBITS-1:0] word_o,      // last completed word
  output logic             word_vld_o   // one-cycle pulse, cycle after done_o
);

  localparam int NBYTES = NBITS / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

  logic [NBITS-1:0] shift_q, shift_d;
  logic [NBITS-1:0] word_q, word_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             vld_q;

  assign word_nxt_o = {shift_q[NBITS-9:0], byte_i};
  assign done_o     = byte_vld_i && !clr_i && (cnt_q == LAST_BYTE);
  assign word_o     = word_q;
  assign word_vld_o = vld_q;

  // Next-state for shift register, byte counter and captured word; clear wins over data.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (byte_vld_i) begin
      shift_d = word_nxt_o;
      cnt_d   = done_o ? '0 : cnt_q + 1'b1;
      if (done_o) word_d = word_nxt_o;
    end
  end

  // State registers; async reset drops any pending word pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      vld_q   <= done_o;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot/debug loader between the UART receiver and the CPU: lock gating, program
// download into instruction memory, free-run and single-step control.
module prog_loader
  import loader_pkg::*;
#(
  parameter int NBITS     = 32,
  parameter int CELDAS_M  = 70,
  parameter int ADDRNBITS = 7,
  parameter int LOCK_CYC  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_locked,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_done,
  input  logic                 i_cpu_halt,
  output logic                 o_imem_wr_en,
  output logic [ADDRNBITS-1:0] o_imem_addr,
  output logic [NBITS-1:0]     o_imem_data,
  output logic                 o_cpu_reset,
  output logic                 o_cpu_enable,
  output logic [2:0]           o_state,
  output logic                 o_full
);

  localparam int LCW = $clog2(LOCK_CYC + 1);
  localparam logic [LCW-1:0]       LOCK_MAX  = LCW'(LOCK_CYC);
  localparam logic [ADDRNBITS-1:0] LAST_ADDR = ADDRNBITS'(CELDAS_M - 1);

  state_e               state_q, state_d;
  logic [LCW-1:0]       lock_cnt_q, lock_cnt_d;
  logic [ADDRNBITS-1:0] addr_q, addr_d;
  logic                 full_q, full_d;
  logic                 cpu_reset_q, cpu_reset_d;
  logic                 cpu_en_q, cpu_en_d;
  logic                 step_pulse;
  logic                 asm_clr;
  logic                 byte_vld;
  logic                 word_done;
  logic [NBITS-1:0]     word_nxt;
  logic [NBITS-1:0]     word_q;
  logic                 word_vld_q;

  // Bytes only feed the assembler while loading with a stable clock.
  assign byte_vld = i_rx_done && i_locked && (state_q == ST_LOAD);

  word_assembler #(.NBITS(NBITS)) u_asm (
    .clk_i      (i_clk),
    .rst_i      (i_reset),
    .clr_i      (asm_clr),
    .byte_vld_i (byte_vld),
    .byte_i     (i_rx_data),
    .done_o     (word_done),
    .word_nxt_o (word_nxt),
    .word_o     (word_q),
    .word_vld_o (word_vld_q)
  );

  assign o_imem_wr_en = word_vld_q;
  assign o_imem_data  = word_q;
  assign o_imem_addr  = addr_q;
  assign o_cpu_reset  = cpu_reset_q;
  assign o_cpu_enable = cpu_en_q;
  assign o_state      = state_q;
  assign o_full       = full_q;

  // Next state, counters and CPU control; lock loss overrides everything at the end.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    addr_d     = addr_q;
    full_d     = full_q;
    step_pulse = 1'b0;
    asm_clr    = 1'b0;

    // Address advances the cycle after a strobe; the final cell holds so it never wraps.
    if (word_vld_q && !full_q) addr_d = addr_q + 1'b1;

    if (i_locked && lock_cnt_q != LOCK_MAX) lock_cnt_d = lock_cnt_q + 1'b1;

    case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_cnt_d == LOCK_MAX) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (i_rx_done) begin
          case (i_rx_data)
            CMD_LOAD: begin
              state_d = ST_LOAD;
              addr_d  = '0;
              full_d  = 1'b0;
              asm_clr = 1'b1;
            end
            CMD_RUN:  state_d = ST_RUN;
            CMD_STEP: state_d = ST_STEP;
            default:  ;
          endcase
        end
      end
      ST_LOAD: begin
        // Decide on the completing byte so IDLE coincides with the strobe.
        if (word_done) begin
          if (addr_q == LAST_ADDR) begin
            full_d  = 1'b1;
            state_d = ST_IDLE;
          end
          if (word_nxt == NBITS'(HALT_WORD)) state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (i_cpu_halt)                                state_d = ST_DONE;
        else if (i_rx_done && i_rx_data == CMD_ABORT) state_d = ST_IDLE;
      end
      ST_STEP: begin
        if (i_cpu_halt) begin
          state_d = ST_DONE;
        end else if (i_rx_done) begin
          if (i_rx_data == CMD_ABORT)     state_d = ST_IDLE;
          else if (i_rx_data == CMD_STEP) step_pulse = 1'b1;
        end
      end
      ST_DONE: begin
        if (i_rx_done) begin
          if (i_rx_data == CMD_ABORT) begin
            state_d = ST_IDLE;
          end else if (i_rx_data == CMD_LOAD) begin
            state_d = ST_LOAD;
            addr_d  = '0;
            full_d  = 1'b0;
            asm_clr = 1'b1;
          end
        end
      end
      default: state_d = ST_WAIT_LOCK;
    endcase

    if (!i_locked) begin
      state_d    = ST_WAIT_LOCK;
      lock_cnt_d = '0;
      step_pulse = 1'b0;
    end

    cpu_reset_d = cpu_in_reset(state_d);
    cpu_en_d    = (state_d == ST_RUN) || step_pulse;
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_WAIT_LOCK;
      lock_cnt_q  <= '0;
      addr_q      <= '0;
      full_q      <= 1'b0;
      cpu_reset_q <= 1'b1;
      cpu_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      addr_q      <= addr_d;
      full_q      <= full_d;
      cpu_reset_q <= cpu_reset_d;
      cpu_en_q    <= cpu_en_d;
    end
  end

endmodule
